// File: rtl/ws2812b_pkg.sv
// Shared types for the ws2812b bar controller: FSM states, GRB channel order,
// the level-to-lit-LED rule and a {g,r,b} color triple.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

    // Byte order on the wire within one LED: G first, then R, then B.
    localparam logic [1:0] CH_G = 2'd0;
    localparam logic [1:0] CH_R = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam int unsigned COLOR_W = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] b;
    } color_t;

    // Rounded scale of a level sample onto 0..strip_len LEDs; 64-bit math so nothing truncates before the shift.
    function automatic int unsigned lit_count(input int unsigned level,
                                              input int unsigned strip_len,
                                              input int unsigned level_bits);
        logic [63:0] prod;
        prod = 64'(level) * 64'(strip_len) + (64'd1 << (level_bits - 1));
        return 32'(prod >> level_bits);
    endfunction

endpackage

// File: rtl/ws2812b_frame_timer.sv
// Free-running frame counter 0..FRAME_CYCLES-1; tick_o is high for the single
// cycle in which the count equals FRAME_CYCLES-1. Runs regardless of downstream state.
module ws2812b_frame_timer #(
    parameter int unsigned FRAME_CYCLES = 1_666_666
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/ws2812b_bar_ctrl.sv
// Renders the latest level sample as a GRB bar and writes one full frame per timer tick into the ws2812b framebuffer.
// Define WS2812B_PEAK_HOLD_EN to add a decaying peak marker drawn all-ones.
module ws2812b_bar_ctrl
    import ws2812b_pkg::*;
#(
    parameter int unsigned STRIP_LEN    = 12,
    parameter int unsigned COLOR_BITS   = 8,
    parameter int unsigned LEVEL_BITS   = 8,
    parameter int unsigned FRAME_CYCLES = 1_666_666,
    parameter int unsigned PEAK_DECAY   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LEVEL_BITS-1:0]           s_level_data,
    input  logic                            s_level_valid,
    output logic                            s_level_ready,
    input  logic [3*COLOR_BITS-1:0]         on_color,
    input  logic [3*COLOR_BITS-1:0]         off_color,
    output logic                            write_en,
    output logic [$clog2(3*STRIP_LEN)-1:0]  write_addr,
    output logic [COLOR_BITS-1:0]           din,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int unsigned NBYTES = 3 * STRIP_LEN;
    localparam int unsigned ADDR_W = $clog2(NBYTES);
    localparam int unsigned LED_W  = $clog2(STRIP_LEN + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

    if (FRAME_CYCLES <= NBYTES + 2 || PEAK_DECAY == 0) begin : g_param_check
        $error("ws2812b_bar_ctrl: FRAME_CYCLES must exceed 3*STRIP_LEN+2 and PEAK_DECAY must be nonzero");
    end

    fsm_state_t              state_q;
    logic                    tick;
    logic                    accept;
    logic                    start;
    logic                    pending_q;
    logic [LEVEL_BITS-1:0]   level_q;
    logic [LED_W-1:0]        lit_now;
    logic [LED_W-1:0]        lit_q;
    logic [3*COLOR_BITS-1:0] on_q;
    logic [3*COLOR_BITS-1:0] off_q;
    logic [LED_W-1:0]        led_q;
    logic [LED_W-1:0]        led_d;
    logic [1:0]              ch_q;
    logic [1:0]              ch_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [COLOR_BITS-1:0]   din_q;
    logic [COLOR_BITS-1:0]   byte_d;
    logic                    ready_q;
    logic                    wen_q;
    logic                    busy_q;
    logic                    done_q;
    logic [LED_W-1:0]        r_lit;
    logic [3*COLOR_BITS-1:0] r_on;
    logic [3*COLOR_BITS-1:0] r_off;
    logic [3*COLOR_BITS-1:0] r_src;

    ws2812b_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign accept  = s_level_valid && ready_q;
    assign start   = (state_q == ST_IDLE) && tick && pending_q;
    assign lit_now = LED_W'(lit_count(32'(level_q), STRIP_LEN, LEVEL_BITS));

`ifdef WS2812B_PEAK_HOLD_EN
    localparam int unsigned DEC_W = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;

    logic [LED_W-1:0] peak_q;
    logic [LED_W-1:0] peak_now;
    logic [LED_W-1:0] peak_snap_q;
    logic [LED_W-1:0] r_peak;
    logic [DEC_W-1:0] decay_q;

    assign peak_now = (lit_now > peak_q) ? lit_now : peak_q;

    // A fresh peak restarts the decay interval so the marker holds for PEAK_DECAY frames at each position.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q      <= '0;
            peak_snap_q <= '0;
            decay_q     <= '0;
        end else if (start) begin
            peak_snap_q <= peak_now;
            if (lit_now >= peak_q) begin
                peak_q  <= lit_now;
                decay_q <= '0;
            end else if (decay_q == DEC_W'(PEAK_DECAY - 1)) begin
                peak_q  <= peak_q - 1'b1;
                decay_q <= '0;
            end else begin
                decay_q <= decay_q + 1'b1;
            end
        end
    end
`endif

    // Byte to present on the next cycle: byte 0 from live inputs at the tick, later bytes from the snapshot.
    always_comb begin
        led_d = '0;
        ch_d  = CH_G;
        r_lit = lit_now;
        r_on  = on_color;
        r_off = off_color;
`ifdef WS2812B_PEAK_HOLD_EN
        r_peak = peak_now;
`endif
        if (state_q == ST_WRITE) begin
            r_lit = lit_q;
            r_on  = on_q;
            r_off = off_q;
`ifdef WS2812B_PEAK_HOLD_EN
            r_peak = peak_snap_q;
`endif
            if (ch_q == CH_B) begin
                ch_d  = CH_G;
                led_d = led_q + 1'b1;
            end else begin
                ch_d  = ch_q + 1'b1;
                led_d = led_q;
            end
        end
        r_src = (led_d < r_lit) ? r_on : r_off;
        case (ch_d)
            CH_G:    byte_d = r_src[3*COLOR_BITS-1 -: COLOR_BITS];
            CH_R:    byte_d = r_src[2*COLOR_BITS-1 -: COLOR_BITS];
            default: byte_d = r_src[COLOR_BITS-1:0];
        endcase
`ifdef WS2812B_PEAK_HOLD_EN
        if (r_peak > r_lit && led_d == r_peak - 1'b1) begin
            byte_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            level_q   <= '0;
            lit_q     <= '0;
            on_q      <= '0;
            off_q     <= '0;
            led_q     <= '0;
            ch_q      <= CH_G;
            addr_q    <= '0;
            din_q     <= '0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A sample taken in the tick cycle lands after the snapshot, so it waits for the next tick.
            if (accept) begin
                level_q   <= s_level_data;
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (start) begin
                        if (!accept) begin
                            pending_q <= 1'b0;
                        end
                        state_q <= ST_WRITE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        wen_q   <= 1'b1;
                        lit_q   <= lit_now;
                        on_q    <= on_color;
                        off_q   <= off_color;
                        led_q   <= led_d;
                        ch_q    <= ch_d;
                        addr_q  <= '0;
                        din_q   <= byte_d;
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= ST_DONE;
                        wen_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                        din_q   <= '0;
                    end else begin
                        led_q  <= led_d;
                        ch_q   <= ch_d;
                        addr_q <= addr_q + 1'b1;
                        din_q  <= byte_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_level_ready = ready_q;
    assign write_en      = wen_q;
    assign write_addr    = addr_q;
    assign din           = din_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule
